ysyx_24090003_mem_arbiter: RTL and testbench
============================================

# ysyx_24090003_mem_arbiter

Multi-cycle memory arbiter and sequencer for the ysyx_24090003 core. It shares one memory port between two requesters: the instruction fetch unit and the load/store path. It allows one outstanding transaction, routes the response back to its owner, and terminates stalled transactions with an error response. It sits between the IFU/EXU memory-side signals and the external memory bus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, cycles a transaction may stay in flight before an error response; 0 disables the watchdog
- cpu_clk  in  1  core clock; all state updates on rising edge
- cpu_rs  in  1  reset; one clock; reset is synchronous and active-low
- ifu_req_valid / ifu_req_ready  in / out  1  fetch request handshake
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch response, one-cycle pulse
- ifu_rdata  out  DATA_W  fetched instruction
- ifu_resp_err  out  1  fetch timed out
- lsu_req_valid / lsu_req_ready  in / out  1  load/store request handshake
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte enables
- lsu_resp_valid, lsu_rdata, lsu_resp_err  out  1, DATA_W, 1  load/store response; same rules as IFU
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W, 1, DATA_W, DATA_W/8  latched request fields
- mem_resp_valid  in  1  memory response valid
- mem_rdata  in  DATA_W  memory read data

## Operation
- States:
  - IDLE: no transaction in flight.
  - REQ: mem_req_valid=1 until mem_req_ready.
  - RESP: waiting for mem_resp_valid.
- IDLE:
  - Exactly one requester's ready is driven high, combinationally: the arbitration winner among asserted valids.
  - Both readies are 0 outside IDLE.
- Accept (valid && ready in IDLE):
  - Latch addr/wen/wdata/wmask into the mem_* registers and record the owner; go to REQ.
  - IFU requests latch wen=0, wdata=0, wmask=0.
- REQ:
  - mem_req_ready=1 → go to RESP.
  - mem_* fields stay stable while mem_req_valid=1.
- RESP: on mem_resp_valid=1:
  - register mem_rdata into the owner's rdata;
  - pulse the owner's resp_valid for one cycle with err=0;
  - go to IDLE.
  - Stores also receive a response; its rdata is whatever memory returns.
- Non-owner resp_valid stays 0; its rdata holds its previous value.
- mem_resp_valid in IDLE or REQ is ignored, with no state change.
- Arbitration is fixed priority: LSU wins when both are valid. A pending EXU access must complete before the next fetch.
- Watchdog (TIMEOUT>0):
  - A counter clears on accept and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT without completion: go to IDLE, deassert mem_req_valid, pulse the owner's resp_valid with err=1 and rdata=0.
  - A completion in the same cycle as the timeout wins: err=0.
- Reset (cpu_rs=0), including mid-transaction:
  - State returns to IDLE; the transaction is dropped with no response.
  - All outputs go to 0: readies, resp_valids, errs, rdata, mem_* fields.
  - The round-robin pointer resets to IFU.

## Timing
- Best case: accept at cycle N, mem_req_valid at N+1, mem_req_ready at N+1, mem_resp_valid at N+2, owner resp_valid at N+3.
- Next accept is possible at N+3, the same cycle as the response pulse.
- Throughput: at most one transaction per 3 cycles.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and does not wrap.

## Configuration
- YSYX_24090003_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the requester that did not win the last grant.
  - The last-grant register updates on every accept and resets to IFU, so the first tie goes to LSU.
  - A lone requester is always granted.
- Undefined: fixed LSU priority; no last-grant register is instantiated.

## Structure
- Package ysyx_24090003_arb_pkg:
  - state enum (IDLE, REQ, RESP);
  - owner enum (OWN_IFU, OWN_LSU);
  - default TIMEOUT constant.
- Sub-module ysyx_24090003_arb_timeout: saturating watchdog counter with clear/enable inputs and an expired output.

## Test plan
- LSU load only, addr=0x80000010, memory ready immediately, rdata=0xDEADBEEF one cycle later → lsu_resp_valid at accept+3 with rdata 0xDEADBEEF, err=0; ifu_resp_valid stays 0.
- Both valid in IDLE, macro off → LSU granted; IFU granted on the next IDLE. Macro on, three consecutive ties → grants LSU, IFU, LSU.
- Store addr=0x80000020, wdata=0x12345678, wmask=0xF, mem_req_ready held 0 for 4 cycles → mem_* fields stable through REQ, one mem handshake, then lsu_resp_valid.
- TIMEOUT=8, memory never responds to an IFU fetch → ifu_resp_valid=1, err=1, rdata=0 exactly 8 cycles after accept; next request is accepted.
- cpu_rs=0 asserted in RESP → next cycle all outputs 0, state IDLE, no response pulse; a late mem_resp_valid is ignored.
- Spurious mem_resp_valid in IDLE with no requests → no resp_valid on either side.

Source files
------------

// File: rtl/ysyx_24090003_arb_pkg.sv
// Shared types and constants for the ysyx_24090003 memory arbiter.
// States, owner tags and the default watchdog limit.
package ysyx_24090003_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  localparam int ARB_TIMEOUT_DEF = 255;

  function automatic arb_owner_t to_owner(input logic is_lsu);
    return is_lsu ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/ysyx_24090003_arb_timeout.sv
// Saturating watchdog: counts in-flight cycles since accept.
// TIMEOUT=0 removes the counter and never expires.
module ysyx_24090003_arb_timeout
  import ysyx_24090003_arb_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT > 0) begin : g_wd
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // The accept cycle counts as the first, so the
    // count reaches TIMEOUT on the edge that expires.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= CW'(1);
      end else if (enable && cnt_q != LIMIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign expired = enable && (cnt_q >= LAST);
  end else begin : g_off
    assign expired = 1'b0;
  end

endmodule

// File: rtl/ysyx_24090003_mem_arbiter.sv
// ysyx_24090003 memory arbiter: IFU and LSU share one memory port.
// Macro YSYX_24090003_ARB_RR_EN selects round-robin tie breaking.
module ysyx_24090003_mem_arbiter
  import ysyx_24090003_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                cpu_clk,
  input  logic                cpu_rs,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q;
  logic       grant_lsu;
  logic       in_idle;
  logic       accept;
  logic       expired;
  logic       resp_fire;
  logic       resp_err;

`ifdef YSYX_24090003_ARB_RR_EN
  arb_owner_t last_q;

  // Remember who won the last grant to alternate on ties.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rs) begin
      last_q <= OWN_IFU;
    end else if (accept) begin
      last_q <= to_owner(grant_lsu);
    end
  end
`endif

  // Pick the winner among asserted requests.
  always_comb begin
    grant_lsu = lsu_req_valid;
`ifdef YSYX_24090003_ARB_RR_EN
    if (lsu_req_valid && ifu_req_valid) begin
      grant_lsu = (last_q == OWN_IFU);
    end
`endif
  end

  assign in_idle       = cpu_rs && (state_q == IDLE);
  assign lsu_req_ready = in_idle && grant_lsu;
  assign ifu_req_ready = in_idle && !grant_lsu && ifu_req_valid;
  assign accept        = (lsu_req_ready && lsu_req_valid)
                      || ifu_req_ready;
  assign mem_req_valid = (state_q == REQ);

  ysyx_24090003_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (cpu_clk),
    .rst_n  (cpu_rs),
    .clear  (accept),
    .enable (state_q != IDLE),
    .expired(expired)
  );

  // Next state plus completion/timeout decision.
  always_comb begin
    state_d   = state_q;
    resp_fire = 1'b0;
    resp_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = REQ;
      end
      REQ: begin
        if (expired) begin
          state_d   = IDLE;
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_resp_valid) begin
          state_d   = IDLE;
          resp_fire = 1'b1;
        end else if (expired) begin
          state_d   = IDLE;
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rs) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the request and route the response to its owner.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rs) begin
      owner_q        <= OWN_IFU;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;
      lsu_rdata      <= '0;
    end else begin
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;
      if (accept) begin
        owner_q   <= to_owner(grant_lsu);
        mem_addr  <= grant_lsu ? lsu_addr : ifu_addr;
        mem_wen   <= grant_lsu && lsu_wen;
        mem_wdata <= grant_lsu ? lsu_wdata : '0;
        mem_wmask <= grant_lsu ? lsu_wmask : '0;
      end
      if (resp_fire) begin
        if (owner_q == OWN_LSU) begin
          lsu_resp_valid <= 1'b1;
          lsu_resp_err   <= resp_err;
          lsu_rdata      <= resp_err ? '0 : mem_rdata;
        end else begin
          ifu_resp_valid <= 1'b1;
          ifu_resp_err   <= resp_err;
          ifu_rdata      <= resp_err ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_mem_arbiter.sv
// Self-checking bench for ysyx_24090003_mem_arbiter (TIMEOUT=8).
// Reference model: grant rule, latency formula, per-side rdata history.
module tb_ysyx_24090003_mem_arbiter;

  localparam int TO = 8;

  logic        cpu_clk;
  logic        cpu_rs;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  ysyx_24090003_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rs(cpu_rs),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int n_run;
  int n_fail;

  bit          m_last_lsu;
  logic [31:0] m_ifu_rd, m_lsu_rd;

  bit          o_none, o_lsu, o_seen, o_stable;
  int          o_ifu_p, o_lsu_p, o_lat, o_hs;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [31:0] c_addr, c_wdata;
  logic        c_wen;
  logic [3:0]  c_wmask;

  function automatic bit exp_grant(input bit iv, input bit lv);
`ifdef YSYX_24090003_ARB_RR_EN
    if (iv && lv) return !m_last_lsu;
`endif
    return lv;
  endfunction

  function automatic int exp_lat(input int rdly, input int sdly);
    if (sdly < 0 || 3 + rdly + sdly > TO) return TO;
    return 3 + rdly + sdly;
  endfunction

  function automatic bit exp_err(input int rdly, input int sdly);
    return (sdly < 0 || 3 + rdly + sdly > TO);
  endfunction

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0;
    lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    idle_inputs();
    cpu_rs = 0;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rs = 1;
    m_last_lsu = 0; m_ifu_rd = 0; m_lsu_rd = 0;
  endtask

  // Drive one request and act as memory; records observations only.
  task automatic do_txn(
    input bit iv, input bit lv,
    input logic [31:0] ia, input logic [31:0] la,
    input logic wen, input logic [31:0] wd, input logic [3:0] wm,
    input int rdly, input int sdly, input logic [31:0] rd);
    int req_n, resp_n;
    bit in_resp;
    o_none = 0; o_lsu = 0; o_seen = 0; o_stable = 1;
    o_ifu_p = 0; o_lsu_p = 0; o_lat = -1; o_hs = 0;
    o_rdata = 0; o_err = 0;
    @(negedge cpu_clk);
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la;
    lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    #1;
    if (!ifu_req_ready && !lsu_req_ready) begin
      o_none = 1;
      ifu_req_valid = 0; lsu_req_valid = 0;
      return;
    end
    o_lsu = lsu_req_ready;
    req_n = 0; resp_n = 0; in_resp = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge cpu_clk);
      ifu_req_valid = 0; lsu_req_valid = 0;
      mem_req_ready = 0; mem_resp_valid = 0;
      mem_rdata = $urandom;
      if (ifu_resp_valid) begin
        o_ifu_p++;
        if (o_lat < 0) begin
          o_lat = k; o_rdata = ifu_rdata; o_err = ifu_resp_err;
        end
      end
      if (lsu_resp_valid) begin
        o_lsu_p++;
        if (o_lat < 0) begin
          o_lat = k; o_rdata = lsu_rdata; o_err = lsu_resp_err;
        end
      end
      if (mem_req_valid) begin
        if (!o_seen) begin
          o_seen = 1;
          c_addr = mem_addr; c_wen = mem_wen;
          c_wdata = mem_wdata; c_wmask = mem_wmask;
        end else if ({mem_addr, mem_wen, mem_wdata, mem_wmask}
                     !== {c_addr, c_wen, c_wdata, c_wmask}) begin
          o_stable = 0;
        end
        if (req_n == rdly) begin
          mem_req_ready = 1; o_hs++; in_resp = 1;
        end
        req_n++;
      end else if (in_resp) begin
        if (sdly >= 0 && resp_n == sdly) begin
          mem_resp_valid = 1; mem_rdata = rd;
        end
        resp_n++;
      end
    end
    mem_req_ready = 0; mem_resp_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge cpu_clk);
    cpu_rs = 0;
    @(negedge cpu_clk);
    #1;
    n_run++;
    if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
         ifu_resp_err, lsu_resp_err, ifu_rdata, lsu_rdata, mem_req_valid,
         mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: some output nonzero (mem_addr=%h rdata=%h/%h)",
               mem_addr, ifu_rdata, lsu_rdata);
    end
    cpu_rs = 1;
  endtask

  task automatic test_lsu_load();
    do_txn(0, 1, 0, 32'h8000_0010, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    n_run++;
    if (o_none || !o_lsu) begin
      n_fail++; $display("FAIL load_grant got none=%0d lsu=%0d want lsu", o_none, o_lsu);
    end
    n_run++;
    if (o_lat !== 3) begin
      n_fail++; $display("FAIL load_latency got %0d want 3", o_lat);
    end
    n_run++;
    if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin
      n_fail++; $display("FAIL load_data got %h err=%b want deadbeef err=0", o_rdata, o_err);
    end
    n_run++;
    if (o_lsu_p !== 1 || o_ifu_p !== 0) begin
      n_fail++; $display("FAIL load_pulses got lsu=%0d ifu=%0d want 1/0", o_lsu_p, o_ifu_p);
    end
    n_run++;
    if (c_addr !== 32'h8000_0010 || c_wen !== 1'b0) begin
      n_fail++; $display("FAIL load_memreq got %h wen=%b want 80000010 wen=0", c_addr, c_wen);
    end
    m_last_lsu = 1; m_lsu_rd = 32'hDEAD_BEEF;
  endtask

  task automatic test_tie();
    bit e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      e = exp_grant(1, 1);
      do_txn(1, 1, 32'h3000_0000 + i, 32'h4000_0000 + i, 0, 0, 0, 0, 0, 32'h100 + i);
      n_run++;
      if (o_none || o_lsu !== e) begin
        n_fail++; $display("FAIL tie_%0d got lsu=%0d none=%0d want lsu=%0d", i, o_lsu, o_none, e);
      end
      n_run++;
      if (o_lsu_p !== int'(e) || o_ifu_p !== int'(!e)) begin
        n_fail++; $display("FAIL tie_owner_%0d got lsu=%0d ifu=%0d want lsu=%0d", i, o_lsu_p, o_ifu_p, e);
      end
      m_last_lsu = e;
      if (e) m_lsu_rd = 32'h100 + i; else m_ifu_rd = 32'h100 + i;
    end
    do_txn(1, 0, 32'h3000_0100, 0, 0, 0, 0, 0, 0, 32'h0000_0AAA);
    n_run++;
    if (o_none || o_lsu !== 1'b0 || c_addr !== 32'h3000_0100) begin
      n_fail++; $display("FAIL ifu_alone got lsu=%0d addr=%h want ifu 30000100", o_lsu, c_addr);
    end
    m_last_lsu = 0; m_ifu_rd = 32'h0000_0AAA;
  endtask

  task automatic test_store_stall();
    do_txn(0, 1, 0, 32'h8000_0020, 1, 32'h1234_5678, 4'hF, 4, 0, 32'h5555_0000);
    n_run++;
    if ({c_addr, c_wen, c_wdata, c_wmask} !== {32'h8000_0020, 1'b1, 32'h1234_5678, 4'hF}) begin
      n_fail++; $display("FAIL store_fields got %h %b %h %h", c_addr, c_wen, c_wdata, c_wmask);
    end
    n_run++;
    if (!o_stable || o_hs !== 1) begin
      n_fail++; $display("FAIL store_stable got stable=%0d hs=%0d want 1/1", o_stable, o_hs);
    end
    n_run++;
    if (o_lsu_p !== 1 || o_lat !== exp_lat(4, 0) || o_err !== 1'b0) begin
      n_fail++; $display("FAIL store_resp got p=%0d lat=%0d err=%b want 1/%0d/0", o_lsu_p, o_lat, o_err, exp_lat(4, 0));
    end
    m_last_lsu = 1; m_lsu_rd = 32'h5555_0000;
  endtask

  task automatic test_timeout();
    do_txn(1, 0, 32'h8000_0100, 0, 0, 0, 0, 0, -1, 0);
    n_run++;
    if (o_ifu_p !== 1 || o_lat !== TO || o_err !== 1'b1 || o_rdata !== 0) begin
      n_fail++; $display("FAIL timeout got p=%0d lat=%0d err=%b rd=%h want 1/%0d/1/0", o_ifu_p, o_lat, o_err, o_rdata, TO);
    end
    m_ifu_rd = 0; m_last_lsu = 0;
    do_txn(0, 1, 0, 32'h8000_0200, 0, 0, 0, 0, 0, 32'hCAFE_F00D);
    n_run++;
    if (o_none || o_lsu_p !== 1 || o_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL after_timeout got none=%0d p=%0d rd=%h want cafef00d", o_none, o_lsu_p, o_rdata);
    end
    m_lsu_rd = 32'hCAFE_F00D; m_last_lsu = 1;
    do_txn(0, 1, 0, 32'h8000_0300, 0, 0, 0, 2, 3, 32'h0BAD_CAFE);
    n_run++;
    if (o_lat !== 8 || o_err !== 1'b0 || o_rdata !== 32'h0BAD_CAFE) begin
      n_fail++; $display("FAIL tie_timeout got lat=%0d err=%b rd=%h want 8/0/0badcafe", o_lat, o_err, o_rdata);
    end
    m_lsu_rd = 32'h0BAD_CAFE;
  endtask

  task automatic test_random();
    bit iv, lv, e, wen, er;
    logic [31:0] ia, la, wd, rd, ea, ed;
    logic [3:0] wm;
    int rdly, sdly, el;
    for (int i = 0; i < 24; i++) begin
      iv = 1'($urandom); lv = 1'($urandom);
      if (!iv && !lv) iv = 1;
      ia = $urandom & 32'hFFFF_FFFC; la = $urandom;
      wen = 1'($urandom); wd = $urandom; wm = 4'($urandom);
      rd = $urandom;
      rdly = $urandom_range(3); sdly = int'($urandom_range(4)) - 1;
      e = exp_grant(iv, lv);
      el = exp_lat(rdly, sdly); er = exp_err(rdly, sdly);
      do_txn(iv, lv, ia, la, wen, wd, wm, rdly, sdly, rd);
      n_run++;
      if (o_none || o_lsu !== e) begin
        n_fail++; $display("FAIL rnd%0d_grant got lsu=%0d want %0d", i, o_lsu, e);
      end
      ea = e ? la : ia;
      n_run++;
      if ({c_addr, c_wen, c_wdata, c_wmask} !== {ea, e & wen, e ? wd : 32'h0, e ? wm : 4'h0}) begin
        n_fail++; $display("FAIL rnd%0d_fields got %h %b %h %h", i, c_addr, c_wen, c_wdata, c_wmask);
      end
      n_run++;
      if (o_lsu_p !== int'(e) || o_ifu_p !== int'(!e)) begin
        n_fail++; $display("FAIL rnd%0d_pulses got lsu=%0d ifu=%0d want lsu side=%0d", i, o_lsu_p, o_ifu_p, e);
      end
      ed = er ? 32'h0 : rd;
      n_run++;
      if (o_lat !== el || o_err !== er || o_rdata !== ed) begin
        n_fail++; $display("FAIL rnd%0d_resp got lat=%0d err=%b rd=%h want %0d/%b/%h", i, o_lat, o_err, o_rdata, el, er, ed);
      end
      m_last_lsu = e;
      if (e) m_lsu_rd = ed; else m_ifu_rd = ed;
      n_run++;
      if (ifu_rdata !== m_ifu_rd || lsu_rdata !== m_lsu_rd) begin
        n_fail++; $display("FAIL rnd%0d_hold got %h/%h want %h/%h", i, ifu_rdata, lsu_rdata, m_ifu_rd, m_lsu_rd);
      end
    end
  endtask

  task automatic test_spurious();
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk);
      mem_resp_valid = 1; mem_rdata = $urandom;
      if (ifu_resp_valid || lsu_resp_valid || mem_req_valid) p++;
    end
    @(negedge cpu_clk);
    mem_resp_valid = 0;
    if (ifu_resp_valid || lsu_resp_valid || mem_req_valid) p++;
    n_run++;
    if (p !== 0 || ifu_rdata !== m_ifu_rd || lsu_rdata !== m_lsu_rd) begin
      n_fail++; $display("FAIL spurious got events=%0d rd=%h/%h want 0 %h/%h", p, ifu_rdata, lsu_rdata, m_ifu_rd, m_lsu_rd);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    @(negedge cpu_clk);
    lsu_req_valid = 1; lsu_addr = 32'h8000_0400; lsu_wen = 0;
    @(negedge cpu_clk);
    lsu_req_valid = 0;
    mem_req_ready = 1;
    @(negedge cpu_clk);
    mem_req_ready = 0;
    cpu_rs = 0; ifu_req_valid = 1;
    @(negedge cpu_clk);
    #1;
    n_run++;
    if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
         ifu_resp_err, lsu_resp_err, ifu_rdata, lsu_rdata, mem_req_valid,
         mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got addr=%h rd=%h/%h rdy=%b%b", mem_addr, ifu_rdata, lsu_rdata, ifu_req_ready, lsu_req_ready);
    end
    cpu_rs = 1; ifu_req_valid = 0;
    m_last_lsu = 0; m_ifu_rd = 0; m_lsu_rd = 0;
    mem_resp_valid = 1; mem_rdata = 32'h7777_7777;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk);
      mem_resp_valid = 0;
      if (ifu_resp_valid || lsu_resp_valid || mem_req_valid) p++;
    end
    n_run++;
    if (p !== 0 || lsu_rdata !== 32'h0) begin
      n_fail++; $display("FAIL midreset_late got events=%0d rd=%h want 0/0", p, lsu_rdata);
    end
    lsu_req_valid = 1; ifu_req_valid = 1;
    #1;
    n_run++;
    if (lsu_req_ready !== exp_grant(1, 1) || ifu_req_ready !== !exp_grant(1, 1)) begin
      n_fail++; $display("FAIL midreset_idle got rdy ifu=%b lsu=%b", ifu_req_ready, lsu_req_ready);
    end
    lsu_req_valid = 0; ifu_req_valid = 0;
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    cpu_rs = 0;
    idle_inputs();
    test_reset();
    do_reset();
    test_lsu_load();
    test_tie();
    test_store_stall();
    test_timeout();
    test_random();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
